// File: rtl/shift_ser_pkg.sv
// Shared types and helpers for the shift-register serial transmitter.
// Holds the FSM state encoding, the serial-order constants and the counter-width helper.
package shift_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } tx_state_e;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word load, LSB- or MSB-first serial output.
// Optional even-parity trailer bit when SHIFT_SER_TX_PARITY_EN is defined.
module shift_ser_tx
    import shift_ser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] p,
    input  logic             dir,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             first,
    output logic             done
);

    // Handshake: a word transfers on a rising edge where load_valid && load_ready;
    // load_ready never depends on load_valid, and p/dir must stay stable until taken.

    localparam int               CW_RAW   = clog2(WIDTH);
    localparam int               CW       = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
`ifdef SHIFT_SER_TX_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'(PAR);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
`ifdef SHIFT_SER_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic busy;
    logic last_bit;
    logic load_acc;

    always_comb begin
        busy = (state_q == ST_SHIFT);
`ifdef SHIFT_SER_TX_PARITY_EN
        busy     = busy || (state_q == ST_PAR);
        last_bit = (state_q == ST_PAR);
`else
        last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);
`endif
        load_ready = (state_q == ST_IDLE) || (last_bit && !hold);
        load_acc   = load_valid && load_ready;
        sout_valid = busy && !hold;
        first      = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST) && !hold;
        done       = last_bit && !hold;
    end

    // sout follows the register directly, so a held cycle keeps showing the current bit.
    always_comb begin
        sout = 1'b0;
        if (state_q == ST_SHIFT) begin
            sout = (dir_q == DIR_MSB_FIRST) ? sreg_q[WIDTH-1] : sreg_q[0];
        end
`ifdef SHIFT_SER_TX_PARITY_EN
        else if (state_q == ST_PAR) begin
            sout = parity_q;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
`ifdef SHIFT_SER_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if ((state_q == ST_SHIFT) && !hold) begin
            if (dir_q == DIR_MSB_FIRST) begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
`ifdef SHIFT_SER_TX_PARITY_EN
                state_d = ST_PAR;
`else
                state_d = ST_IDLE;
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

`ifdef SHIFT_SER_TX_PARITY_EN
        if ((state_q == ST_PAR) && !hold) begin
            state_d = ST_IDLE;
        end
`endif

        // A load on the final-bit edge overrides the return to IDLE: no gap between words.
        if (load_acc) begin
            state_d  = ST_SHIFT;
            sreg_d   = p;
            dir_d    = dir;
            cnt_d    = CNT_LAST;
`ifdef SHIFT_SER_TX_PARITY_EN
            parity_d = ^p;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_LSB_FIRST;
`ifdef SHIFT_SER_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
`ifdef SHIFT_SER_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_ser_tx.sv
// Self-checking bench for shift_ser_tx: directed scenarios plus random traffic,
// with a bit-level expected queue compared against every valid serial bit.
module tb_shift_ser_tx;

    localparam int WIDTH = 4;
`ifdef SHIFT_SER_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = WIDTH + PB;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] p;
    logic             dir;
    logic             load_valid;
    logic             load_ready;
    logic             hold;
    logic             sout;
    logic             sout_valid;
    logic             first;
    logic             done;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    logic [0:0] exp_q[$];

    shift_ser_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .p          (p),
        .dir        (dir),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .hold       (hold),
        .sout       (sout),
        .sout_valid (sout_valid),
        .first      (first),
        .done       (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit idx of the serial stream for word w sent with order d (idx == WIDTH is parity).
    function automatic logic word_bit(input logic [WIDTH-1:0] w, input logic d, input int idx);
        if (idx >= WIDTH) return ^w;
        return d ? w[WIDTH-1-idx] : w[idx];
    endfunction

    task automatic push_word(input logic [WIDTH-1:0] w, input logic d);
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(word_bit(w, d, i));
        end
    endtask

    // Inputs change on the falling edge; outputs are inspected 1 ns later.
    task automatic tick(input logic lv, input logic [WIDTH-1:0] pw, input logic d, input logic h);
        @(negedge clk);
        load_valid = lv;
        p          = pw;
        dir        = d;
        hold       = h;
        #1;
    endtask

    // scoreboard: every valid serial bit must match the head of the expected queue
    always @(negedge clk) begin
        logic [0:0] e;
        #2;
        if (!reset && sout_valid) begin
            assert_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL scoreboard_extra t=%0t: got bit %b, want no bit", $time, sout);
            end else begin
                e = exp_q.pop_front();
                if (sout !== e[0]) begin
                    fail_cnt++;
                    $display("FAIL scoreboard_bit t=%0t: got %b want %b", $time, sout, e[0]);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; p = '0; dir = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        assert_cnt++; if (sout !== 1'b0)       begin fail_cnt++; $display("FAIL reset_sout: got %b want 0", sout); end
        assert_cnt++; if (sout_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_sout_valid: got %b want 0", sout_valid); end
        assert_cnt++; if (first !== 1'b0)      begin fail_cnt++; $display("FAIL reset_first: got %b want 0", first); end
        assert_cnt++; if (done !== 1'b0)       begin fail_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        assert_cnt++; if (load_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, '0, 1'b0, 1'b1);
        assert_cnt++; if (sout_valid !== 1'b0 || load_ready !== 1'b1) begin
            fail_cnt++; $display("FAIL idle_hold: got valid=%b ready=%b want 0/1", sout_valid, load_ready);
        end
    endtask

    task automatic test_lsb_first();
        tick(1'b1, 4'b1000, 1'b0, 1'b0);
        assert_cnt++; if (load_ready !== 1'b1) begin fail_cnt++; $display("FAIL lsb_accept: got %b want 1", load_ready); end
        push_word(4'b1000, 1'b0);
        for (int c = 1; c <= NB; c++) begin
            tick(1'b0, 4'b1000, 1'b0, 1'b0);
            assert_cnt++; if (sout_valid !== 1'b1) begin fail_cnt++; $display("FAIL lsb_valid c%0d: got %b want 1", c, sout_valid); end
            assert_cnt++; if (first !== (c == 1)) begin fail_cnt++; $display("FAIL lsb_first c%0d: got %b want %b", c, first, c == 1); end
            assert_cnt++; if (done !== (c == NB)) begin fail_cnt++; $display("FAIL lsb_done c%0d: got %b want %b", c, done, c == NB); end
            assert_cnt++; if (load_ready !== (c == NB)) begin fail_cnt++; $display("FAIL lsb_ready c%0d: got %b want %b", c, load_ready, c == NB); end
        end
        tick(1'b0, 4'b1000, 1'b0, 1'b0);
        assert_cnt++; if (load_ready !== 1'b1 || sout_valid !== 1'b0 || sout !== 1'b0) begin
            fail_cnt++; $display("FAIL lsb_idle: got ready=%b valid=%b sout=%b want 1/0/0", load_ready, sout_valid, sout);
        end
        assert_cnt++; if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL lsb_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_msb_first();
        logic [WIDTH-1:0] sr;
        int n;
        sr = '0; n = 0;
        tick(1'b1, 4'b1001, 1'b1, 1'b0);
        push_word(4'b1001, 1'b1);
        for (int c = 1; c <= NB; c++) begin
            // a word offered mid-stream must be ignored
            tick(c == 2, (c == 2) ? 4'b0110 : 4'b1001, 1'b1, 1'b0);
            if (c == 2) begin
                assert_cnt++; if (load_ready !== 1'b0) begin fail_cnt++; $display("FAIL msb_busy_ready: got %b want 0", load_ready); end
            end
            if (sout_valid && n < WIDTH) begin
                sr = {sr[WIDTH-2:0], sout};
                n++;
            end
        end
        assert_cnt++; if (sr !== 4'b1001) begin fail_cnt++; $display("FAIL msb_shiftreg_q: got %b want 1001", sr); end
        tick(1'b0, 4'b1001, 1'b1, 1'b0);
        assert_cnt++; if (exp_q.size() != 0 || sout_valid !== 1'b0) begin
            fail_cnt++; $display("FAIL msb_drain: got %0d left valid=%b want 0/0", exp_q.size(), sout_valid);
        end
    endtask

    task automatic test_hold();
        int idx;
        logic h;
        idx = 0;
        tick(1'b1, 4'b1010, 1'b0, 1'b0);
        push_word(4'b1010, 1'b0);
        // hold on steps 2,3 and on the first visit of the final bit
        for (int s = 1; s <= NB + 3; s++) begin
            h = (s == 2) || (s == 3) || (s == NB + 2);
            tick(1'b0, 4'b1010, 1'b0, h);
            assert_cnt++; if (sout_valid !== !h) begin fail_cnt++; $display("FAIL hold_valid s%0d: got %b want %b", s, sout_valid, !h); end
            assert_cnt++; if (sout !== word_bit(4'b1010, 1'b0, idx)) begin
                fail_cnt++; $display("FAIL hold_sout s%0d: got %b want %b", s, sout, word_bit(4'b1010, 1'b0, idx));
            end
            assert_cnt++; if (done !== (!h && idx == NB - 1)) begin
                fail_cnt++; $display("FAIL hold_done s%0d: got %b want %b", s, done, !h && idx == NB - 1);
            end
            assert_cnt++; if (load_ready !== (!h && idx == NB - 1)) begin
                fail_cnt++; $display("FAIL hold_ready s%0d: got %b want %b", s, load_ready, !h && idx == NB - 1);
            end
            assert_cnt++; if (first !== (s == 1)) begin fail_cnt++; $display("FAIL hold_first s%0d: got %b want %b", s, first, s == 1); end
            if (!h) idx++;
        end
        tick(1'b0, 4'b1010, 1'b0, 1'b0);
        assert_cnt++; if (exp_q.size() != 0 || sout_valid !== 1'b0) begin
            fail_cnt++; $display("FAIL hold_drain: got %0d left valid=%b want 0/0", exp_q.size(), sout_valid);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        done_cnt = 0;
        tick(1'b1, 4'b1010, 1'b0, 1'b0);
        push_word(4'b1010, 1'b0);
        for (int c = 1; c <= 2 * NB; c++) begin
            tick(c == NB, (c >= NB) ? 4'b0110 : 4'b1010, c >= NB, 1'b0);
            if (c == NB) begin
                assert_cnt++; if (load_ready !== 1'b1) begin fail_cnt++; $display("FAIL b2b_overlap_ready: got %b want 1", load_ready); end
                push_word(4'b0110, 1'b1);
            end
            assert_cnt++; if (sout_valid !== 1'b1) begin fail_cnt++; $display("FAIL b2b_gap c%0d: got %b want 1", c, sout_valid); end
            assert_cnt++; if (first !== (c == 1 || c == NB + 1)) begin
                fail_cnt++; $display("FAIL b2b_first c%0d: got %b want %b", c, first, c == 1 || c == NB + 1);
            end
            if (done) done_cnt++;
        end
        assert_cnt++; if (done_cnt != 2) begin fail_cnt++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
        tick(1'b0, 4'b0110, 1'b1, 1'b0);
        assert_cnt++; if (exp_q.size() != 0 || sout_valid !== 1'b0) begin
            fail_cnt++; $display("FAIL b2b_drain: got %0d left valid=%b want 0/0", exp_q.size(), sout_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        int done_cnt;
        done_cnt = 0;
        tick(1'b1, 4'b1111, 1'b0, 1'b0);
        push_word(4'b1111, 1'b0);
        tick(1'b0, 4'b1111, 1'b0, 1'b0);
        tick(1'b0, 4'b1111, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        assert_cnt++; if (sout !== 1'b0 || sout_valid !== 1'b0 || first !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL abort_outputs: got sout=%b valid=%b first=%b done=%b ready=%b want 0/0/0/0/1",
                     sout, sout_valid, first, done, load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 4'b0001, 1'b0, 1'b0);
        push_word(4'b0001, 1'b0);
        for (int c = 1; c <= NB + 1; c++) begin
            tick(1'b0, 4'b0001, 1'b0, 1'b0);
            if (done) done_cnt++;
        end
        assert_cnt++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL abort_next_done: got %0d want 1", done_cnt); end
        assert_cnt++; if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL abort_drain: got %0d left want 0", exp_q.size()); end
    endtask

`ifdef SHIFT_SER_TX_PARITY_EN
    task automatic test_parity();
        tick(1'b1, 4'b1011, 1'b0, 1'b0);
        push_word(4'b1011, 1'b0);
        for (int c = 1; c <= NB; c++) begin
            tick(1'b0, 4'b1011, 1'b0, 1'b0);
            if (c == NB) begin
                assert_cnt++; if (sout !== 1'b1 || done !== 1'b1) begin
                    fail_cnt++; $display("FAIL parity_bit: got sout=%b done=%b want 1/1", sout, done);
                end
            end
        end
        tick(1'b0, 4'b1011, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] w;
        logic             d;
        logic             lv;
        logic             h;
        int               words;
        words = 0;
        w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        d = 1'($urandom_range(0, 1));
        for (int c = 0; c < 300 && words < 20; c++) begin
            lv = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 3) == 0);
            tick(lv, w, d, h);
            if (lv && load_ready) begin
                push_word(w, d);
                words++;
                w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                d = 1'($urandom_range(0, 1));
            end
        end
        for (int c = 0; c < NB + 2; c++) begin
            tick(1'b0, w, d, 1'b0);
        end
        assert_cnt++; if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL random_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_hold();
        test_back_to_back();
        test_reset_mid_word();
`ifdef SHIFT_SER_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
